// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the 5-stage pipeline hazard/sequencing logic.
//   - FWD_*     : encodings of the ID-stage operand mux select
//   - state_t   : hazard controller state (RUN / BUSY)
//   - REG_ZERO  : architectural zero register, never a forwarding source
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;  // register file read data
    localparam logic [1:0] FWD_EALU = 2'b01;  // ALU result sitting in EXE
    localparam logic [1:0] FWD_MALU = 2'b10;  // ALU result sitting in MEM
    localparam logic [1:0] FWD_MMO  = 2'b11;  // load data coming out of MEM

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage : pipe_pkg

// File: rtl/fwd_sel.sv
// ----------------------------------------------------------------------------
// fwd_sel
//   Forwarding select for one ID-stage source operand. Compares the source
//   register against the EXE and MEM destinations; the younger EXE result
//   wins over MEM. A load in EXE cannot be forwarded (its data does not
//   exist yet) and is left to the load-use stall.
//
//   Ports:
//     src     in  5  ID source register number
//     ern     in  5  EXE destination register
//     ewreg   in  1  EXE writes the register file
//     em2reg  in  1  EXE instruction is a load
//     mrn     in  5  MEM destination register
//     mwreg   in  1  MEM writes the register file
//     mm2reg  in  1  MEM instruction is a load
//     fwd     out 2  operand mux select (FWD_* encoding)
// ----------------------------------------------------------------------------
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] ern,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] mrn,
    input  logic       mwreg,
    input  logic       mm2reg,
    output logic [1:0] fwd
);

    logic e_hit;
    logic m_hit;

    assign e_hit = ewreg && (ern != REG_ZERO) && (ern == src);
    assign m_hit = mwreg && (mrn != REG_ZERO) && (mrn == src);

    // NOTE: fwd gets its default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        fwd = FWD_RF;
        if (e_hit && !em2reg) begin
            fwd = FWD_EALU;
        end else if (m_hit) begin
            fwd = mm2reg ? FWD_MMO : FWD_MALU;
        end
    end

endmodule : fwd_sel

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage pipeline, sitting beside
//   the decoder in ID. Produces operand forwarding selects, stalls on
//   load-use hazards, flushes IF/ID on taken branches and holds EXE while a
//   multi-cycle MDU op (MDU_LAT cycles total) occupies it.
//
//   Parameters:
//     MDU_LAT  total EXE occupancy of an MDU op, 1..7 (1 = never BUSY)
//     CNT_W    occupancy counter width, must hold MDU_LAT-1
//
//   Ports:
//     clk, clrn              clock (rising edge), async active-low reset
//     id_valid/id_rs/id_rt   ID instruction and its source registers
//     id_use_rs/id_use_rt    ID instruction actually reads rs / rt
//     id_mdu                 ID instruction is an MDU op
//     br_taken               ID branch/jump resolved taken
//     ern/ewreg/em2reg       EXE destination, write enable, is-load
//     mrn/mwreg/mm2reg       MEM destination, write enable, is-load
//     fwda/fwdb              rs / rt operand selects
//     wpcir                  PC and IF/ID write enable
//     flush_if               IF/ID loads a nop
//     ide_en / ide_nop       ID/EXE write enable / load a bubble
//     em_nop                 EXE/MEM loads a bubble
//     mdu_busy               controller is in BUSY
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_mdu,
    input  logic       br_taken,
    input  logic [4:0] ern,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] mrn,
    input  logic       mwreg,
    input  logic       mm2reg,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       wpcir,
    output logic       flush_if,
    output logic       ide_en,
    output logic       ide_nop,
    output logic       em_nop,
    output logic       mdu_busy
);

    // The entry edge itself is one EXE cycle, so BUSY lasts MDU_LAT-1 cycles.
    localparam bit               MDU_MULTI = (MDU_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lu;

    // ------------------------------------------------------------------
    // Forwarding: identical rules for both operands, valid in any state.
    // ------------------------------------------------------------------
    fwd_sel u_fwd_a (
        .src    (id_rs),
        .ern    (ern),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .mrn    (mrn),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .fwd    (fwda)
    );

    fwd_sel u_fwd_b (
        .src    (id_rt),
        .ern    (ern),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .mrn    (mrn),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .fwd    (fwdb)
    );

    // ------------------------------------------------------------------
    // Load-use: a load in EXE feeding a register the ID instruction reads.
    // Only meaningful in RUN; in BUSY the ID instruction is frozen anyway.
    // ------------------------------------------------------------------
    assign lu = (state == ST_RUN) && id_valid && ewreg && em2reg &&
                (ern != REG_ZERO) &&
                ((id_use_rs && (ern == id_rs)) || (id_use_rt && (ern == id_rt)));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_RUN;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and pipeline control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wpcir     = 1'b1;
        ide_en    = 1'b1;
        ide_nop   = 1'b0;
        em_nop    = 1'b0;
        flush_if  = 1'b0;
        mdu_busy  = 1'b0;

        unique case (state)
            ST_RUN: begin
                if (lu) begin
                    // Hold PC/IF/ID, push a bubble into EXE. The bubble
                    // still has to be written, so ide_en stays high.
                    wpcir   = 1'b0;
                    ide_nop = 1'b1;
                end else begin
                    flush_if = br_taken && id_valid;
                    if (MDU_MULTI && id_valid && id_mdu) begin
                        state_nxt = ST_BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end

            ST_BUSY: begin
                // Freeze everything upstream of EXE and keep the unfinished
                // MDU op out of MEM.
                wpcir    = 1'b0;
                ide_en   = 1'b0;
                em_nop   = 1'b1;
                mdu_busy = 1'b1;
                if (cnt == CNT_ONE) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Three instances share all inputs and
//   differ only in MDU_LAT (4, 1, 3). Inputs change 1 time unit after the
//   rising edge; outputs are compared 1 unit later, well before the next edge.
//   Control outputs are compared as a packed vector
//   {wpcir, ide_en, ide_nop, em_nop, flush_if, mdu_busy}.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    // Expected control vectors
    localparam logic [5:0] C_RUN   = 6'b110000;
    localparam logic [5:0] C_LU    = 6'b011000;
    localparam logic [5:0] C_BUSY  = 6'b000101;
    localparam logic [5:0] C_FLUSH = 6'b110010;

    logic       clk;
    logic       clrn;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_mdu;
    logic       br_taken;
    logic [4:0] ern;
    logic       ewreg;
    logic       em2reg;
    logic [4:0] mrn;
    logic       mwreg;
    logic       mm2reg;

    logic [1:0] fwda_4, fwdb_4, fwda_1, fwdb_1, fwda_3, fwdb_3;
    logic       wpcir_4, flush_if_4, ide_en_4, ide_nop_4, em_nop_4, mdu_busy_4;
    logic       wpcir_1, flush_if_1, ide_en_1, ide_nop_1, em_nop_1, mdu_busy_1;
    logic       wpcir_3, flush_if_3, ide_en_3, ide_nop_3, em_nop_3, mdu_busy_3;
    logic [5:0] ctl_4, ctl_1, ctl_3;

    int n_total;
    int n_bad;

    assign ctl_4 = {wpcir_4, ide_en_4, ide_nop_4, em_nop_4, flush_if_4, mdu_busy_4};
    assign ctl_1 = {wpcir_1, ide_en_1, ide_nop_1, em_nop_1, flush_if_1, mdu_busy_1};
    assign ctl_3 = {wpcir_3, ide_en_3, ide_nop_3, em_nop_3, flush_if_3, mdu_busy_3};

    pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(3)) u_dut4 (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_mdu(id_mdu), .br_taken(br_taken),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .fwda(fwda_4), .fwdb(fwdb_4), .wpcir(wpcir_4), .flush_if(flush_if_4),
        .ide_en(ide_en_4), .ide_nop(ide_nop_4), .em_nop(em_nop_4), .mdu_busy(mdu_busy_4)
    );

    pipe_hazard_ctrl #(.MDU_LAT(1), .CNT_W(3)) u_dut1 (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_mdu(id_mdu), .br_taken(br_taken),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .fwda(fwda_1), .fwdb(fwdb_1), .wpcir(wpcir_1), .flush_if(flush_if_1),
        .ide_en(ide_en_1), .ide_nop(ide_nop_1), .em_nop(em_nop_1), .mdu_busy(mdu_busy_1)
    );

    pipe_hazard_ctrl #(.MDU_LAT(3), .CNT_W(3)) u_dut3 (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_mdu(id_mdu), .br_taken(br_taken),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .fwda(fwda_3), .fwdb(fwdb_3), .wpcir(wpcir_3), .flush_if(flush_if_3),
        .ide_en(ide_en_3), .ide_nop(ide_nop_3), .em_nop(em_nop_3), .mdu_busy(mdu_busy_3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid  = 1'b0;
        id_rs     = 5'd0;
        id_rt     = 5'd0;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        id_mdu    = 1'b0;
        br_taken  = 1'b0;
        ern       = 5'd0;
        ewreg     = 1'b0;
        em2reg    = 1'b0;
        mrn       = 5'd0;
        mwreg     = 1'b0;
        mm2reg    = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clrn = 1'b0;
        idle_inputs();
        #1;
        if (ctl_4 !== C_RUN) begin
            n_bad++; $display("FAIL reset_ctl4 got=%b want=%b", ctl_4, C_RUN);
        end
        n_total++;
        if (ctl_1 !== C_RUN) begin
            n_bad++; $display("FAIL reset_ctl1 got=%b want=%b", ctl_1, C_RUN);
        end
        n_total++;
        if ({fwda_4, fwdb_4} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_fwd got=%b want=0000", {fwda_4, fwdb_4});
        end
        n_total++;
        #11 clrn = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_forwarding();
        idle_inputs();
        ewreg = 1'b1; em2reg = 1'b0; ern = 5'd5; id_rs = 5'd5;
        mwreg = 1'b1; mm2reg = 1'b0; mrn = 5'd5;
        #1;
        if (fwda_4 !== 2'b01) begin
            n_bad++; $display("FAIL fwd_exe_priority got=%b want=01", fwda_4);
        end
        n_total++;
        ern = 5'd6;
        #1;
        if (fwda_4 !== 2'b10) begin
            n_bad++; $display("FAIL fwd_mem_alu got=%b want=10", fwda_4);
        end
        n_total++;
        mm2reg = 1'b1;
        #1;
        if (fwda_4 !== 2'b11) begin
            n_bad++; $display("FAIL fwd_mem_load got=%b want=11", fwda_4);
        end
        n_total++;
        // rt sees the EXE ALU result on r6 while rs keeps the MEM load
        id_rt = 5'd6;
        #1;
        if ({fwda_4, fwdb_4} !== 4'b1101) begin
            n_bad++; $display("FAIL fwd_both got=%b want=1101", {fwda_4, fwdb_4});
        end
        n_total++;
        // A load in EXE is never a forwarding source
        em2reg = 1'b1; mwreg = 1'b0;
        #1;
        if (fwdb_4 !== 2'b00) begin
            n_bad++; $display("FAIL fwd_exe_load got=%b want=00", fwdb_4);
        end
        n_total++;
        // r0 never forwards even though everything matches
        em2reg = 1'b0; mwreg = 1'b1; mm2reg = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; ern = 5'd0; mrn = 5'd0;
        #1;
        if ({fwda_4, fwdb_4} !== 4'b0000) begin
            n_bad++; $display("FAIL fwd_zero_reg got=%b want=0000", {fwda_4, fwdb_4});
        end
        n_total++;
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_use();
        idle_inputs();
        id_valid = 1'b1; id_mdu = 1'b1;
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd8;
        id_rt = 5'd8; id_use_rt = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
        #1;
        if (ctl_4 !== C_LU) begin
            n_bad++; $display("FAIL lu_rt got=%b want=%b", ctl_4, C_LU);
        end
        n_total++;
        // Bubble now in EXE; the MDU op must not have entered BUSY
        step();
        ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0; id_mdu = 1'b0;
        #1;
        if (ctl_4 !== C_RUN) begin
            n_bad++; $display("FAIL lu_release got=%b want=%b", ctl_4, C_RUN);
        end
        n_total++;
        // rs path
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3;
        #1;
        if (ctl_3 !== C_LU) begin
            n_bad++; $display("FAIL lu_rs got=%b want=%b", ctl_3, C_LU);
        end
        n_total++;
        // Matching register but not actually read: no stall
        id_use_rs = 1'b0;
        #1;
        if (ctl_4 !== C_RUN) begin
            n_bad++; $display("FAIL lu_unused got=%b want=%b", ctl_4, C_RUN);
        end
        n_total++;
        // Load to r0 never stalls
        id_use_rs = 1'b1; id_rs = 5'd0; ern = 5'd0;
        #1;
        if (ctl_4 !== C_RUN) begin
            n_bad++; $display("FAIL lu_zero_reg got=%b want=%b", ctl_4, C_RUN);
        end
        n_total++;
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_mdu();
        idle_inputs();
        id_valid = 1'b1; id_mdu = 1'b1;
        #1;
        if ({mdu_busy_4, mdu_busy_1, mdu_busy_3} !== 3'b000) begin
            n_bad++; $display("FAIL mdu_entry_cycle got=%b want=000",
                              {mdu_busy_4, mdu_busy_1, mdu_busy_3});
        end
        n_total++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) id_mdu = 1'b0;
            // Load-use conditions while BUSY must be ignored
            if (i == 1) begin
                ewreg = 1'b1; em2reg = 1'b1; ern = 5'd8; id_rt = 5'd8; id_use_rt = 1'b1;
            end
            if (i == 2) begin
                ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
            end
            #1;
            if (ctl_4 !== ((i < 3) ? C_BUSY : C_RUN)) begin
                n_bad++; $display("FAIL mdu4_cycle%0d got=%b want=%b", i, ctl_4,
                                  (i < 3) ? C_BUSY : C_RUN);
            end
            n_total++;
            if (ctl_3 !== ((i < 2) ? C_BUSY : C_RUN)) begin
                n_bad++; $display("FAIL mdu3_cycle%0d got=%b want=%b", i, ctl_3,
                                  (i < 2) ? C_BUSY : C_RUN);
            end
            n_total++;
            if (ctl_1 !== ((i == 1) ? C_LU : C_RUN)) begin
                n_bad++; $display("FAIL mdu1_cycle%0d got=%b want=%b", i, ctl_1,
                                  (i == 1) ? C_LU : C_RUN);
            end
            n_total++;
        end
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_branch();
        idle_inputs();
        id_valid = 1'b1; br_taken = 1'b1;
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
        #1;
        if (ctl_4 !== C_LU) begin
            n_bad++; $display("FAIL br_with_lu got=%b want=%b", ctl_4, C_LU);
        end
        n_total++;
        step();
        ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
        #1;
        if (ctl_4 !== C_FLUSH) begin
            n_bad++; $display("FAIL br_flush got=%b want=%b", ctl_4, C_FLUSH);
        end
        n_total++;
        id_valid = 1'b0;
        #1;
        if (ctl_4 !== C_RUN) begin
            n_bad++; $display("FAIL br_invalid got=%b want=%b", ctl_4, C_RUN);
        end
        n_total++;
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_busy();
        idle_inputs();
        id_valid = 1'b1; id_mdu = 1'b1;
        step();                 // u_dut4 now BUSY, cnt=3
        id_mdu = 1'b0;
        step();                 // cnt=2
        if (ctl_4 !== C_BUSY) begin
            n_bad++; $display("FAIL rstb_pre got=%b want=%b", ctl_4, C_BUSY);
        end
        n_total++;
        #3 clrn = 1'b0;
        #1;
        if (ctl_4 !== C_RUN) begin
            n_bad++; $display("FAIL rstb_async got=%b want=%b", ctl_4, C_RUN);
        end
        n_total++;
        #2 clrn = 1'b1;
        step();
        if (ctl_4 !== C_RUN) begin
            n_bad++; $display("FAIL rstb_after got=%b want=%b", ctl_4, C_RUN);
        end
        n_total++;
        id_mdu = 1'b1;
        step();
        id_mdu = 1'b0;
        #1;
        if (ctl_4 !== C_BUSY) begin
            n_bad++; $display("FAIL rstb_reenter got=%b want=%b", ctl_4, C_BUSY);
        end
        n_total++;
        step(); step(); step();
        if (ctl_4 !== C_RUN) begin
            n_bad++; $display("FAIL rstb_drain got=%b want=%b", ctl_4, C_RUN);
        end
        n_total++;
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        // Cycle c0..c6, bit i = expected mdu_busy in cycle ci
        logic [6:0] exp3;
        logic [6:0] exp4;
        exp3 = 7'b0110110;
        exp4 = 7'b0001110;
        idle_inputs();
        id_valid = 1'b1; id_mdu = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            // Second MDU op has entered u_dut3 by c4; the next instruction is plain
            if (i == 4) id_mdu = 1'b0;
            #1;
            if (mdu_busy_3 !== exp3[i]) begin
                n_bad++; $display("FAIL b2b_lat3_c%0d got=%b want=%b", i, mdu_busy_3, exp3[i]);
            end
            n_total++;
            if (mdu_busy_4 !== exp4[i]) begin
                n_bad++; $display("FAIL b2b_lat4_c%0d got=%b want=%b", i, mdu_busy_4, exp4[i]);
            end
            n_total++;
            if (mdu_busy_1 !== 1'b0) begin
                n_bad++; $display("FAIL b2b_lat1_c%0d got=%b want=0", i, mdu_busy_1);
            end
            n_total++;
        end
        idle_inputs();
        step();
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_branch();
        test_reset_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
